uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver. Configurable data width, parity and stop bits.

---
 rtl/uart_rx_cfg.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, parity and stop bits; frames queue in a small FIFO.
// Latency: a frame is pushed at the middle of its last stop bit; rx_valid rises the following cycle.
// Backpressure: rx_ready pops the head; a completed frame meeting a full FIFO without a pop is dropped and flagged.
module uart_rx_cfg #(
   parameter int CLOCK_FREQ  = 100000000,
   parameter int BAUD_RATE   = 2000000,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 uart_clock,
   input  logic                 uart_reset,
   input  logic                 uart_d_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_break,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun_err
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = 4;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int WORD_W       = DATA_BITS + 3;

   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic [PTR_W:0]   CNT_FULL      = (PTR_W + 1)'(FIFO_DEPTH);
   localparam bit               HAS_PARITY    = (PARITY_MODE != 0);
   localparam logic             ODD_PARITY    = (PARITY_MODE == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // line synchroniser and edge history (idle line reads as 1)
   logic sync_ff;
   logic rxs;
   logic rxs_prev;

   // receive FSM
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] bit_cnt_next;
   logic [IDX_W-1:0] bit_idx;
   logic [IDX_W-1:0] bit_idx_next;
   logic             sample_data;
   logic             sample_parity;
   logic             sample_stop;
   logic             push;

   // frame being assembled
   logic [DATA_BITS-1:0] data_sr;
   logic                 parity_bit;
   logic                 stop_err;
   logic                 stop_low;

   // completed frame word
   logic              frame_err_w;
   logic              parity_err_w;
   logic              break_w;
   logic [WORD_W-1:0] push_word;

   // frame FIFO
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              full;
   logic              pop;
   logic              wr_en;
   logic              drop;
   logic [WORD_W-1:0] head;

   // two-flop synchroniser plus one history flop for falling-edge detection
   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         sync_ff  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         sync_ff  <= uart_d_in;
         rxs      <= sync_ff;
         rxs_prev <= rxs;
      end
   end

   // FSM state, bit timer and bit index registers
   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         bit_idx <= bit_idx_next;
      end
   end

   // next-state logic: mid-bit sampling strobes, push at the middle of the last stop bit
   always_comb begin
      state_next    = state;
      bit_cnt_next  = bit_cnt;
      bit_idx_next  = bit_idx;
      sample_data   = 1'b0;
      sample_parity = 1'b0;
      sample_stop   = 1'b0;
      push          = 1'b0;
      case (state)
         ST_IDLE: begin
            bit_cnt_next = '0;
            bit_idx_next = '0;
            // only a 1->0 transition starts a frame, so a held-low line cannot retrigger
            if (rxs_prev && !rxs) begin
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (bit_cnt == CNT_HALF) begin
               bit_cnt_next = '0;
               bit_idx_next = '0;
               // a start bit gone high again by mid-bit is a glitch
               state_next   = rxs ? ST_IDLE : ST_DATA;
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_cnt == CNT_LAST) begin
               bit_cnt_next = '0;
               sample_data  = 1'b1;
               if (bit_idx == IDX_DATA_LAST) begin
                  bit_idx_next = '0;
                  state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         ST_PARITY: begin
            if (bit_cnt == CNT_LAST) begin
               bit_cnt_next  = '0;
               sample_parity = 1'b1;
               state_next    = ST_STOP;
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_cnt == CNT_LAST) begin
               bit_cnt_next = '0;
               sample_stop  = 1'b1;
               if (bit_idx == IDX_STOP_LAST) begin
                  // leave at mid-bit so a back-to-back start edge is not missed
                  bit_idx_next = '0;
                  push         = 1'b1;
                  state_next   = ST_IDLE;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // frame capture: shift data LSB first, remember parity bit and stop-bit history
   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         data_sr    <= '0;
         parity_bit <= 1'b0;
         stop_err   <= 1'b0;
         stop_low   <= 1'b1;
      end else begin
         if (state == ST_IDLE) begin
            parity_bit <= 1'b0;
            stop_err   <= 1'b0;
            stop_low   <= 1'b1;
         end
         if (sample_data) begin
            data_sr <= {rxs, data_sr[DATA_BITS-1:1]};
         end
         if (sample_parity) begin
            parity_bit <= rxs;
         end
         if (sample_stop) begin
            if (!rxs) begin
               stop_err <= 1'b1;
            end else begin
               stop_low <= 1'b0;
            end
         end
      end
   end

   // the last stop sample is still on rxs in the push cycle, so fold it in here
   always_comb begin
      frame_err_w  = stop_err | ~rxs;
      parity_err_w = HAS_PARITY && ((^data_sr ^ parity_bit) != ODD_PARITY);
      break_w      = (data_sr == '0) && !parity_bit && stop_low && !rxs;
      push_word    = {break_w, frame_err_w, parity_err_w, data_sr};
   end

   assign full  = (count == CNT_FULL);
   assign pop   = rx_valid && rx_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   // FIFO pointers, occupancy and overrun pulse; a pop frees the slot a same-cycle push needs
   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overrun_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         overrun_err <= drop;
      end
   end

   // FIFO storage; contents are only visible while occupancy is non-zero
   always_ff @(posedge uart_clock) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_word;
      end
   end

   assign head          = mem[rd_ptr];
   assign rx_valid      = (count != '0);
   assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_parity_err = rx_valid & head[DATA_BITS];
   assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
   assign rx_break      = rx_valid & head[DATA_BITS+2];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E2, 9O1 with a 2-deep FIFO) on separate lines.
// Directed steps plus random frames; expected words come from a frame-level model queue.
// Consumer ready is driven per step to exercise hold, drain, overrun and push-with-pop.
module tb_uart_rx_cfg;

   localparam int CPB   = 50;
   localparam int HALF  = 25;
   localparam int DB    [3] = '{8, 7, 9};
   localparam int PM    [3] = '{0, 1, 2};
   localparam int SBITS [3] = '{1, 2, 1};
   // start edge on the pin to the push of an 8N1 frame: 2 sync flops, half bit, 8 data + 1 stop bits
   localparam int PUSH_AT = 2 + HALF + (8 + 1) * CPB;

   typedef struct packed {
      logic [15:0] data;
      logic        p;
      logic        f;
      logic        b;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] line;
   logic [2:0] rdy;
   logic [2:0] vld;
   logic [2:0] perr;
   logic [2:0] ferr;
   logic [2:0] brk;
   logic [2:0] ovr;
   logic [7:0] d0;
   logic [6:0] d1;
   logic [8:0] d2;

   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;

   uart_rx_cfg u0 (
      .uart_clock(clk), .uart_reset(rst_n), .uart_d_in(line[0]),
      .rx_data(d0), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_break(brk[0]),
      .rx_valid(vld[0]), .rx_ready(rdy[0]), .overrun_err(ovr[0])
   );

   uart_rx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
      .uart_clock(clk), .uart_reset(rst_n), .uart_d_in(line[1]),
      .rx_data(d1), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_break(brk[1]),
      .rx_valid(vld[1]), .rx_ready(rdy[1]), .overrun_err(ovr[1])
   );

   uart_rx_cfg #(.DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
      .uart_clock(clk), .uart_reset(rst_n), .uart_d_in(line[2]),
      .rx_data(d2), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_break(brk[2]),
      .rx_valid(vld[2]), .rx_ready(rdy[2]), .overrun_err(ovr[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mask_of(input int sel);
      return (16'(1) << DB[sel]) - 16'(1);
   endfunction

   function automatic logic [15:0] head_data(input int sel);
      case (sel)
         0:       return {8'h00, d0};
         1:       return {9'h000, d1};
         default: return {7'h00, d2};
      endcase
   endfunction

   // parity bit a correct transmitter would send
   function automatic logic par_ok(input int sel, input logic [15:0] data);
      int ones;
      ones = $countones(data & mask_of(sel));
      return (PM[sel] == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   // drive one frame on line[sel]; optionally queue what the receiver should report for it
   task automatic send_frame(input int sel, input logic [15:0] data, input logic par,
                             input logic [1:0] stops, input bit model);
      logic [15:0] bits;
      logic [15:0] dm;
      int          n;
      int          ones;
      exp_t        e;
      bit          any_zero;
      bit          all_zero;
      dm       = data & mask_of(sel);
      ones     = $countones(dm);
      any_zero = !stops[0] || (SBITS[sel] == 2 && !stops[1]);
      all_zero = !stops[0] && (SBITS[sel] == 1 || !stops[1]);
      e.data   = dm;
      e.p      = (PM[sel] != 0) && (((ones + int'(par)) % 2) != ((PM[sel] == 2) ? 1 : 0));
      e.f      = any_zero;
      e.b      = (dm == 16'h0) && (PM[sel] == 0 || !par) && all_zero;
      if (model) sb.push_back(e);
      bits = '0;
      n    = 1;
      for (int i = 0; i < DB[sel]; i++) begin
         bits[n] = dm[i];
         n++;
      end
      if (PM[sel] != 0) begin
         bits[n] = par;
         n++;
      end
      for (int s = 0; s < SBITS[sel]; s++) begin
         bits[n] = stops[s];
         n++;
      end
      for (int i = 0; i < n; i++) begin
         line[sel] = bits[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   // wait (bounded) for a head frame, compare it with the model, then pop it
   task automatic check_head(input int sel, input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (!vld[sel] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_vld"}, 32'(vld[sel]), 32'd1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      chk(tag, 32'({head_data(sel), perr[sel], ferr[sel], brk[sel]}), 32'(e));
      rdy[sel] = 1'b1;
      @(negedge clk);
      rdy[sel] = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      int          vc;
      int          oc;
      exp_t        e;
      logic [15:0] d;
      logic        p;
      logic [1:0]  st;
      int          sel;

      line  = 3'b111;
      rdy   = 3'b000;
      rst_n = 1'b0;
      got   = '0;
      repeat (5) @(negedge clk);
      chk("rst_ctl", 32'({vld, perr, ferr, brk, ovr}), 32'd0);
      chk("rst_dat", 32'({d0, d1, d2}), 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 0xA5 8N1 with consumer always ready: a single valid cycle
      rdy[0] = 1'b1;
      vc     = 0;
      fork
         send_frame(0, 16'h00A5, 1'b0, 2'b11, 1'b1);
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (vld[0]) begin
               vc++;
               got = 32'({head_data(0), perr[0], ferr[0], brk[0]});
            end
         end
      join
      rdy[0] = 1'b0;
      chk("t1_vld_cycles", 32'(vc), 32'd1);
      chk("t1_const", got, 32'({16'h00A5, 3'b000}));
      e = sb.pop_front();
      chk("t1_model", got, 32'(e));

      // even parity on 0x07: parity bit 1 is good, 0 is bad
      send_frame(1, 16'h0007, 1'b1, 2'b11, 1'b1);
      chk("t2_perr_clr", 32'(perr[1]), 32'd0);
      check_head(1, "t2_par_ok");
      send_frame(1, 16'h0007, 1'b0, 2'b11, 1'b1);
      chk("t2_perr_set", 32'(perr[1]), 32'd1);
      check_head(1, "t2_par_bad");

      // 20-cycle low glitch is rejected; a following frame is still received
      line[0] = 1'b0;
      repeat (20) @(negedge clk);
      line[0] = 1'b1;
      repeat (150) @(negedge clk);
      chk("t3_no_push", 32'(vld[0]), 32'd0);
      send_frame(0, 16'h005A, 1'b0, 2'b11, 1'b1);
      check_head(0, "t3_after_glitch");

      // stop bit 0 is a framing error, not a break
      send_frame(0, 16'h003C, 1'b0, 2'b00, 1'b1);
      line[0] = 1'b1;
      repeat (60) @(negedge clk);
      chk("t4_ferr_only", 32'({ferr[0], brk[0]}), 32'd2);
      check_head(0, "t4_frame");

      // line held low for three frame times yields exactly one break frame
      line[0] = 1'b0;
      repeat (3 * 10 * CPB) @(negedge clk);
      line[0] = 1'b1;
      repeat (100) @(negedge clk);
      e.data = 16'h0;
      e.p    = 1'b0;
      e.f    = 1'b1;
      e.b    = 1'b1;
      sb.push_back(e);
      chk("t4_brk_flags", 32'({ferr[0], brk[0], d0}), 32'({2'b11, 8'h00}));
      check_head(0, "t4_break");
      repeat (600) @(negedge clk);
      chk("t4_break_once", 32'(vld[0]), 32'd0);

      // five frames into a 4-deep FIFO with no consumer: one overrun, first four kept
      for (int k = 1; k <= 4; k++) send_frame(0, 16'(k), 1'b0, 2'b11, 1'b1);
      oc = 0;
      fork
         send_frame(0, 16'h0005, 1'b0, 2'b11, 1'b0);
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (ovr[0]) oc++;
         end
      join
      chk("t5_ovr_pulses", 32'(oc), 32'd1);
      for (int k = 0; k < 4; k++) check_head(0, "t5_drain");
      chk("t5_empty", 32'(vld[0]), 32'd0);

      // full FIFO, pop exactly in the push cycle: frame accepted, no overrun
      for (int k = 0; k < 4; k++) send_frame(0, 16'h0011 + 16'(k), 1'b0, 2'b11, 1'b1);
      oc = 0;
      fork
         send_frame(0, 16'h0016, 1'b0, 2'b11, 1'b1);
         for (int c = 0; c < 560; c++) begin
            rdy[0] = (c == PUSH_AT);
            if (c == PUSH_AT) begin
               e = sb.pop_front();
               chk("t5_pp_head", 32'({head_data(0), perr[0], ferr[0], brk[0]}), 32'(e));
            end
            @(negedge clk);
            if (ovr[0]) oc++;
         end
      join
      rdy[0] = 1'b0;
      chk("t5_pp_ovr", 32'(oc), 32'd0);
      for (int k = 0; k < 4; k++) check_head(0, "t5_pp_drain");
      chk("t5_pp_empty", 32'(vld[0]), 32'd0);

      // reset mid-DATA of a second frame while the first is queued
      send_frame(0, 16'h00C3, 1'b0, 2'b11, 1'b1);
      chk("t6_queued", 32'(vld[0]), 32'd1);
      fork
         send_frame(0, 16'h0033, 1'b0, 2'b11, 1'b0);
         begin
            repeat (4 * CPB) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk("t6_rst_ctl", 32'({vld, perr, ferr, brk, ovr}), 32'd0);
            chk("t6_rst_dat", 32'({d0, d1, d2}), 32'd0);
         end
      join
      sb.delete();
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_empty", 32'(vld[0]), 32'd0);
      send_frame(0, 16'h005A, 1'b0, 2'b11, 1'b1);
      check_head(0, "t6_clean");

      // 7E2 frames back to back with no idle gap
      for (int k = 0; k < 4; k++) begin
         d = 16'($urandom_range(0, 127));
         send_frame(1, d, par_ok(1, d), 2'b11, 1'b1);
      end
      for (int k = 0; k < 4; k++) check_head(1, "b2b");
      chk("b2b_empty", 32'(vld[1]), 32'd0);

      // random frames on 8N1 and 9O1: random data, parity errors, framing errors, breaks
      for (int k = 0; k < 12; k++) begin
         sel = (k % 2 == 0) ? 0 : 2;
         d   = 16'($urandom);
         if ($urandom_range(0, 4) == 0) d = 16'h0;
         p   = par_ok(sel, d) ^ 1'($urandom_range(0, 1));
         st  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
         send_frame(sel, d, p, st, 1'b1);
         line[sel] = 1'b1;
         repeat (80) @(negedge clk);
         check_head(sel, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
